// File: rtl/conv_window_if.sv
// Handshake and line-buffer control bundle between the pixel source, the
// window sequencer and the kernel pipeline tail.
interface conv_window_if #(
  parameter int IMAGE_WIDTH = 512
) ();
  localparam int CW = $clog2(IMAGE_WIDTH);

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          lb_wr_en;
  logic [CW-1:0] lb_wr_addr;
  logic          lb_rotate;
  logic          win_valid;
  logic          kernel_en;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          frame_done;

  // Source/sink side: drives the pixel stream and result back-pressure.
  modport master (
    output start, in_valid, out_ready,
    input  in_ready, lb_wr_en, lb_wr_addr, lb_rotate, win_valid,
           kernel_en, out_valid, out_last, busy, frame_done
  );

  // Sequencer side.
  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, lb_wr_en, lb_wr_addr, lb_rotate, win_valid,
           kernel_en, out_valid, out_last, busy, frame_done
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// 3x3 convolution window sequencer: counts the raster stream, drives the
// line-buffer write/rotate controls, flags interior windows and tracks them
// through the kernel pipeline so the tail knows when a result is valid and
// which one closes the frame. A stalled result freezes the whole pipeline.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; no pixels accepted
// S_FILL  | rows 0 and 1 being loaded, no complete window yet
// S_RUN   | rows 2.. being loaded, interior pixels emit windows
// S_DRAIN | all pixels taken, waiting for the final result handshake
module conv_window_ctrl #(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int PIPE_LAT     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_window_if.slave  bus
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [PIPE_LAT-1:0]   vsr_q, vsr_d;
  logic [PIPE_LAT-1:0]   lsr_q, lsr_d;
  logic                  frame_done_q, frame_done_d;

  logic out_valid;
  logic out_last;
  logic kernel_en;
  logic in_ready;
  logic acc;
  logic col_last;
  logic row_last;
  logic win_valid;
  logic win_last;
  logic final_hs;

  // Pipeline tail status, back-pressure and pixel accept qualification.
  always_comb begin
    out_valid = vsr_q[PIPE_LAT-1];
    out_last  = lsr_q[PIPE_LAT-1] && out_valid;
    kernel_en = !out_valid || bus.out_ready;
    in_ready  = ((state_q == S_FILL) || (state_q == S_RUN)) && kernel_en;
    acc       = bus.in_valid && in_ready;
    col_last  = (col_q == COL_LAST);
    row_last  = (row_q == ROW_LAST);
    win_valid = acc && (row_q >= RW'(2)) && (col_q >= CW'(2));
    win_last  = win_valid && row_last && col_last;
    final_hs  = out_valid && bus.out_ready && out_last;
  end

  // Raster position: cleared when a frame is armed, advanced per accept.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if ((state_q == S_IDLE) && bus.start) begin
      col_d = '0;
      row_d = '0;
    end else if (acc) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window-valid and frame-last tags ride alongside the kernel datapath.
  always_comb begin
    vsr_d = vsr_q;
    lsr_d = lsr_q;
    if (kernel_en) begin
      vsr_d    = vsr_q << 1;
      lsr_d    = lsr_q << 1;
      vsr_d[0] = win_valid;
      lsr_d[0] = win_last;
    end
  end

  // Frame sequencing: next state and the end-of-frame pulse.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FILL;
      end
      S_FILL: begin
        if (acc && col_last && (row_q == RW'(1))) state_d = S_RUN;
      end
      S_RUN: begin
        if (acc && col_last && row_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (final_hs) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, tag shift registers and frame_done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      vsr_q        <= '0;
      lsr_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      vsr_q        <= vsr_d;
      lsr_q        <= lsr_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line-buffer controls are combinational so writes land on the accept edge.
  always_comb begin
    bus.in_ready   = in_ready;
    bus.lb_wr_en   = acc;
    bus.lb_wr_addr = col_q;
    bus.lb_rotate  = acc && col_last;
    bus.win_valid  = win_valid;
    bus.kernel_en  = kernel_en;
    bus.out_valid  = out_valid;
    bus.out_last   = out_last;
    bus.busy       = (state_q != S_IDLE);
    bus.frame_done = frame_done_q;
  end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: three instances (4x4/lat2, 5x3/lat3, 6x5/lat4)
// run from one directed sequence. A per-cycle reference model predicts every
// output; a scoreboard of expected results (due time, last tag) is pushed on
// predicted windows and popped on result handshakes.
module tb_conv_window_ctrl;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_s     [NI];
  logic       in_valid_s  [NI];
  logic       out_ready_s [NI];
  logic       in_ready_s  [NI];
  logic       wr_en_s     [NI];
  logic       rot_s       [NI];
  logic       win_s       [NI];
  logic       ken_s       [NI];
  logic       ov_s        [NI];
  logic       last_s      [NI];
  logic       busy_s      [NI];
  logic       fd_s        [NI];
  logic [7:0] addr_s      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GW = (g == 0) ? 4 : ((g == 1) ? 5 : 6);
    localparam int GH = (g == 0) ? 4 : ((g == 1) ? 3 : 5);
    localparam int GP = (g == 0) ? 2 : ((g == 1) ? 3 : 4);
    conv_window_if #(.IMAGE_WIDTH(GW)) bus ();
    conv_window_ctrl #(.IMAGE_WIDTH(GW), .IMAGE_HEIGHT(GH), .PIPE_LAT(GP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign bus.start     = start_s[g];
    assign bus.in_valid  = in_valid_s[g];
    assign bus.out_ready = out_ready_s[g];
    assign in_ready_s[g] = bus.in_ready;
    assign wr_en_s[g]    = bus.lb_wr_en;
    assign rot_s[g]      = bus.lb_rotate;
    assign win_s[g]      = bus.win_valid;
    assign ken_s[g]      = bus.kernel_en;
    assign ov_s[g]       = bus.out_valid;
    assign last_s[g]     = bus.out_last;
    assign busy_s[g]     = bus.busy;
    assign fd_s[g]       = bus.frame_done;
    assign addr_s[g]     = 8'(bus.lb_wr_addr);
  end

  int mw [NI] = '{4, 5, 6};
  int mh [NI] = '{4, 3, 5};
  int mp [NI] = '{2, 3, 4};

  // reference model state (mst: 0 idle, 1 accepting, 2 draining)
  int          mst [NI];
  int          col_m [NI];
  int          row_m [NI];
  int          ken_cnt [NI];
  bit          fd_m [NI];
  int          due_q [NI][16];
  bit          lastf_q [NI][16];
  int          wp [NI];
  int          rp [NI];
  int          nacc [NI];
  int          nres [NI];
  int          nlast [NI];
  int          lastidx [NI];
  int          nfd [NI];
  logic [63:0] winmask [NI];
  logic [63:0] rotmask [NI];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] obs_vec(input int k);
    return {in_ready_s[k], wr_en_s[k], rot_s[k], win_s[k], ken_s[k], ov_s[k],
            last_s[k], busy_s[k], fd_s[k], addr_s[k]};
  endfunction

  task automatic mreset(input int k);
    mst[k] = 0; col_m[k] = 0; row_m[k] = 0; ken_cnt[k] = 0;
    fd_m[k] = 1'b0; wp[k] = 0; rp[k] = 0;
  endtask

  task automatic check_inst(input int k);
    int m0;
    bit eov, eken, eir, eacc, ewin, erot, elast;
    logic [16:0] exp;
    m0    = mst[k];
    eov   = (wp[k] != rp[k]) && (due_q[k][rp[k] % 16] == ken_cnt[k]);
    eken  = !eov || out_ready_s[k];
    eir   = (m0 == 1) && eken;
    eacc  = in_valid_s[k] && eir;
    ewin  = eacc && (row_m[k] >= 2) && (col_m[k] >= 2);
    erot  = eacc && (col_m[k] == mw[k] - 1);
    elast = eov && lastf_q[k][rp[k] % 16];
    exp   = {eir, eacc, erot, ewin, eken, eov, elast, (m0 != 0), fd_m[k], 8'(col_m[k])};
    chk($sformatf("outs%0d", k), 64'(obs_vec(k)), 64'(exp));
    if (fd_s[k]) nfd[k]++;
    fd_m[k] = 1'b0;
    if (eacc) begin
      nacc[k]++;
      if (win_s[k]) winmask[k] |= (64'd1 << nacc[k]);
      if (rot_s[k]) rotmask[k] |= (64'd1 << nacc[k]);
    end
    if (ewin) begin
      due_q[k][wp[k] % 16]   = ken_cnt[k] + mp[k];
      lastf_q[k][wp[k] % 16] = (row_m[k] == mh[k] - 1) && (col_m[k] == mw[k] - 1);
      wp[k]++;
    end
    if (eov && out_ready_s[k]) begin
      rp[k]++;
      nres[k]++;
      if (elast) begin
        nlast[k]++;
        lastidx[k] = nres[k];
        mst[k]     = 0;
        fd_m[k]    = 1'b1;
      end
    end
    if (eken) ken_cnt[k]++;
    if (eacc) begin
      if (col_m[k] == mw[k] - 1) begin
        col_m[k] = 0;
        if (row_m[k] == mh[k] - 1) begin
          row_m[k] = 0;
          mst[k]   = 2;
        end else begin
          row_m[k]++;
        end
      end else begin
        col_m[k]++;
      end
    end
    if (start_s[k] && m0 == 0) begin
      mst[k] = 1; col_m[k] = 0; row_m[k] = 0;
      nacc[k] = 0; nres[k] = 0; nlast[k] = 0; lastidx[k] = 0; nfd[k] = 0;
      winmask[k] = '0; rotmask[k] = '0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_inst(k);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k);
    start_s[k] = 1'b1;
    cyc();
    start_s[k] = 1'b0;
  endtask

  task automatic feed(input int k, input int n, input int bound);
    in_valid_s[k] = 1'b1;
    for (int i = 0; i < bound && nacc[k] < n; i++) cyc();
    in_valid_s[k] = 1'b0;
    chk($sformatf("nacc%0d", k), 64'(nacc[k]), 64'(n));
  endtask

  task automatic wait_idle(input int k, input int bound);
    for (int i = 0; i < bound && mst[k] != 0; i++) cyc();
    chk($sformatf("drain_timeout%0d", k), 64'(mst[k] == 0), 64'd1);
    cyc();
    cyc();
  endtask

  task automatic frame_a(input string tag);
    pulse_start(0);
    feed(0, 16, 200);
    wait_idle(0, 200);
    chk({tag, "_winmask"}, winmask[0], 64'h19800);
    chk({tag, "_nres"}, 64'(nres[0]), 64'd4);
    chk({tag, "_lastidx"}, 64'(lastidx[0]), 64'd4);
    chk({tag, "_nlast"}, 64'(nlast[0]), 64'd1);
    chk({tag, "_nfd"}, 64'(nfd[0]), 64'd1);
  endtask

  initial begin
    bit stalled;
    logic [7:0] addr_snap;
    for (int k = 0; k < NI; k++) begin
      start_s[k] = 1'b0; in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b1;
      mreset(k);
      nacc[k] = 0; nres[k] = 0; nlast[k] = 0; lastidx[k] = 0; nfd[k] = 0;
      winmask[k] = '0; rotmask[k] = '0;
    end
    #1;
    cyc();
    cyc();
    for (int k = 0; k < NI; k++) chk($sformatf("reset_vals%0d", k), 64'(obs_vec(k)), 64'h01000);
    rst_n = 1'b1;
    cyc();

    // in_valid while idle: never accepted
    in_valid_s[0] = 1'b1;
    repeat (3) cyc();
    chk("idle_in_ready", 64'(in_ready_s[0]), 64'd0);
    chk("idle_addr", 64'(addr_s[0]), 64'd0);
    in_valid_s[0] = 1'b0;

    // 4x4 back-to-back frame
    frame_a("A");

    // 4x4 frame with a downstream stall and a start during the stall
    stalled = 1'b0;
    pulse_start(0);
    in_valid_s[0] = 1'b1;
    for (int i = 0; i < 200 && nacc[0] < 16; i++) begin
      cyc();
      if (!stalled && ov_s[0]) begin
        out_ready_s[0] = 1'b0;
        addr_snap = addr_s[0];
        start_s[0] = 1'b1;
        cyc();
        start_s[0] = 1'b0;
        repeat (5) cyc();
        chk("B_stall_ken", 64'(ken_s[0]), 64'd0);
        chk("B_stall_in_ready", 64'(in_ready_s[0]), 64'd0);
        chk("B_stall_ov", 64'(ov_s[0]), 64'd1);
        chk("B_stall_addr", 64'(addr_s[0]), 64'(addr_snap));
        out_ready_s[0] = 1'b1;
        stalled = 1'b1;
      end
    end
    in_valid_s[0] = 1'b0;
    chk("B_stalled", 64'(stalled), 64'd1);
    chk("B_nacc", 64'(nacc[0]), 64'd16);
    wait_idle(0, 200);
    chk("B_nres", 64'(nres[0]), 64'd4);
    chk("B_lastidx", 64'(lastidx[0]), 64'd4);
    chk("B_nfd", 64'(nfd[0]), 64'd1);

    // 5x3: rotate on accepts 5, 10, 15
    pulse_start(1);
    feed(1, 15, 200);
    wait_idle(1, 200);
    chk("C_rotmask", rotmask[1], 64'h8420);
    chk("C_nres", 64'(nres[1]), 64'd3);
    chk("C_lastidx", 64'(lastidx[1]), 64'd3);
    chk("C_nfd", 64'(nfd[1]), 64'd1);

    // 6x5 with random input gaps and random back-pressure
    pulse_start(2);
    for (int i = 0; i < 3000 && mst[2] != 0; i++) begin
      in_valid_s[2]  = ($urandom_range(0, 1) == 1);
      out_ready_s[2] = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid_s[2]  = 1'b0;
    out_ready_s[2] = 1'b1;
    wait_idle(2, 50);
    chk("D_nres", 64'(nres[2]), 64'd12);
    chk("D_lastidx", 64'(lastidx[2]), 64'd12);
    chk("D_nlast", 64'(nlast[2]), 64'd1);
    chk("D_nfd", 64'(nfd[2]), 64'd1);

    // reset during RUN with results in flight
    pulse_start(0);
    feed(0, 12, 100);
    rst_n = 1'b0;
    #1;
    chk("E_async_reset", 64'(obs_vec(0)), 64'h01000);
    for (int k = 0; k < NI; k++) mreset(k);
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("E_no_frame_done", 64'(nfd[0]), 64'd0);
    chk("E_idle_busy", 64'(busy_s[0]), 64'd0);

    // fresh frame after reset
    frame_a("F");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencer for the 3x3 convolution datapath (Gaussian and Sobel kernel engines). It accepts a raster pixel stream from the UART receive path and drives the line-buffer write and rotate controls. It also issues a window-valid strobe for every interior pixel and stalls the whole kernel pipeline under downstream back-pressure. It sits between the UART RX byte stream and the kernel engines, and feeds results toward UART TX.

## Interface
- IMAGE_WIDTH, 512, pixels per row; minimum 3
- IMAGE_HEIGHT, 512, rows per frame; minimum 3
- PIPE_LAT, 4, kernel datapath latency in enabled cycles; minimum 1
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that arms a frame; ignored unless idle
- in_valid  in  1  input pixel available
- in_ready  out  1  controller accepts the pixel
- lb_wr_en  out  1  write the current pixel into the line buffer
- lb_wr_addr  out  $clog2(IMAGE_WIDTH)  column address for the write
- lb_rotate  out  1  rotate line buffers; pulses on the last column of each row
- win_valid  out  1  3x3 window complete; centre is at (row-1, col-1)
- kernel_en  out  1  stage enable for all kernel pipeline registers
- out_valid  in/out: out  1  kernel result valid at the pipeline tail
- out_last  out  1  marks the final result of the frame
- out_ready  in  1  downstream (TX) accepts the result
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last result is accepted

## Operation
- Accept: acc = in_valid && in_ready.
- in_ready = (state is FILL or RUN) && kernel_en.
- kernel_en = !out_valid || out_ready. A stalled result freezes the full pipeline.
- Counters:
  - col: width $clog2(IMAGE_WIDTH); row: width $clog2(IMAGE_HEIGHT).
  - Both advance only on acc.
  - col wraps from IMAGE_WIDTH-1 to 0, incrementing row.
- lb_wr_en = acc; lb_wr_addr = col (current, pre-increment).
- lb_rotate = acc && col == IMAGE_WIDTH-1.
- win_valid = acc && row >= 2 && col >= 2. There is no border padding, so each frame yields (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) results.
- Valid shift register vsr[PIPE_LAT-1:0] and tag register lsr:
  - Both shift only when kernel_en.
  - vsr[0] loads win_valid.
  - lsr[0] loads win_valid && row == IMAGE_HEIGHT-1 && col == IMAGE_WIDTH-1.
  - out_valid = vsr[PIPE_LAT-1]; out_last = lsr[PIPE_LAT-1] && out_valid.
- State machine:
  - IDLE: start → FILL. Clear col and row.
  - FILL (row < 2): on acc of the last pixel of row 1 → RUN.
  - RUN: on acc of pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) → DRAIN.
  - DRAIN: in_ready = 0. On out_valid && out_ready && out_last → IDLE, and frame_done is registered high for one cycle.
- busy = state != IDLE.
- start while busy is ignored. start and the final handshake in the same cycle: start is ignored and the FSM returns to IDLE.
- in_valid while idle or draining is not accepted; no counter moves.

## Timing
- Reset (async on rst_n low) gives:
  - state IDLE; col and row 0; vsr and lsr 0.
  - Outputs: in_ready 0, lb_wr_en 0, lb_rotate 0, win_valid 0, out_valid 0, out_last 0, busy 0, frame_done 0, lb_wr_addr 0.
  - kernel_en 1, since out_valid is 0.
- Reset mid-frame discards all in-flight results with no frame_done. A frame is rearmed only by a new start.
- start sampled at edge N: busy and in_ready are high from cycle N+1.
- lb_wr_en, lb_wr_addr, lb_rotate and win_valid are combinational from acc, so line-buffer writes occur on the same edge as the accept.
- Latency: the result for a window appears on out_valid exactly PIPE_LAT kernel_en-high cycles after its win_valid cycle.
- out_valid holds with out_ready low; the result is consumed only on out_valid && out_ready.
- Throughput: one pixel and one result per cycle with no stalls.
- frame_done is asserted in the cycle after the final result handshake.

## Test plan
- W=4, H=4, PIPE_LAT=2:
  - start, then 16 back-to-back pixels with out_ready=1 → win_valid at accepts 11, 12, 15, 16.
  - 4 out_valid pulses follow, out_last on the 4th.
  - frame_done 1 cycle after the 4th; busy falls the same cycle.
- Same config, out_ready held low after the first result appears:
  - out_valid holds, kernel_en=0, in_ready=0, counters frozen.
  - Release → remaining results arrive in order with no loss or duplication.
- lb_rotate check, W=5, H=3: exactly 3 pulses, on accepts 5, 10 and 15; lb_wr_addr cycles 0..4.
- Random in_valid gaps, W=6, H=5 → exactly 12 results, out_last only on the 12th, frame_done once.
- start asserted mid-frame → no effect on counters.
- in_valid asserted in IDLE → in_ready stays 0.
- rst_n pulled low during RUN → all outputs return to reset values immediately.
- New start after reset → a full frame completes correctly.
